jk_drive_seq: RTL and testbench

JK_DRIVE_SEQ -- requirements
Module: jk_drive_seq

---
 rtl/jk_drive_pkg.sv | 35 +++
 rtl/jk_drive_seq_excite.sv | 17 +
 rtl/jk_drive_seq.sv | 156 +++++++++++++++
 tb/tb_jk_drive_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drive_pkg.sv
// Shared types and helpers for the JK flip-flop bank drive sequencer.
// Holds the FSM state encoding, command opcodes and per-bit JK excitation.
package jk_drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD       = 2'b00,
    OP_COUNT_UP   = 2'b01,
    OP_COUNT_DOWN = 2'b10,
    OP_COMPLEMENT = 2'b11
  } op_t;

  localparam logic [7:0] STEPS_LOAD = 8'd1;

  // Minimal excitation: only pulse J or K when the bit actually has to move,
  // so an unchanged bit sees J=K=0 (hold) and never toggles by accident.
  function automatic logic [1:0] jk_excite_bit(input logic q, input logic target);
    logic [1:0] w_jk;
    unique case ({q, target})
      2'b00:   w_jk = 2'b00;
      2'b01:   w_jk = 2'b10;
      2'b10:   w_jk = 2'b01;
      default: w_jk = 2'b00;
    endcase
    return w_jk;
  endfunction

endpackage

// File: rtl/jk_drive_seq_excite.sv
// Combinational WIDTH-bit JK excitation: current Q and target in, J/K out.
module jk_excite
  import jk_drive_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign {o_j[b], o_k[b]} = jk_excite_bit(i_q[b], i_target[b]);
  end

endmodule

// File: rtl/jk_drive_seq.sv
// Command sequencer that steps an external JK flip-flop bank toward a target
// value one step at a time, verifying the bank's Q feedback after every drive.
module jk_drive_seq
  import jk_drive_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_steps,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [7:0]       r_steps;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_err;

  state_t           w_state_nxt;
  op_t              w_op_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [7:0]       w_steps_nxt;
  logic [7:0]       w_steps_dec;
  logic [WIDTH-1:0] w_expected_nxt;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic             w_err_nxt;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_j_calc;
  logic [WIDTH-1:0] w_k_calc;

  // Target is always derived from live feedback, so multi-step counts track
  // what the bank really holds rather than an internal shadow copy.
  always_comb begin
    w_target = r_data;
    unique case (r_op)
      OP_LOAD:       w_target = r_data;
      OP_COUNT_UP:   w_target = q_fb + WIDTH'(1);
      OP_COUNT_DOWN: w_target = q_fb - WIDTH'(1);
      OP_COMPLEMENT: w_target = ~q_fb;
      default:       w_target = r_data;
    endcase
  end

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .i_q      (q_fb),
    .i_target (w_target),
    .o_j      (w_j_calc),
    .o_k      (w_k_calc)
  );

  assign w_steps_dec = r_steps - 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_data_nxt     = r_data;
    w_steps_nxt    = r_steps;
    w_expected_nxt = r_expected;
    w_j_nxt        = '0;
    w_k_nxt        = '0;
    w_err_nxt      = r_err;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt    = op_t'(cmd_op);
          w_data_nxt  = cmd_data;
          w_steps_nxt = (op_t'(cmd_op) == OP_LOAD) ? STEPS_LOAD : cmd_steps;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_CALC;
        end
      end

      ST_CALC: begin
        // Zero remaining steps only happens for a zero-step non-LOAD command.
        if (r_steps == 8'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_expected_nxt = w_target;
          w_j_nxt        = w_j_calc;
          w_k_nxt        = w_k_calc;
          w_state_nxt    = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        w_state_nxt = ST_CHECK;
      end

      ST_CHECK: begin
        if (q_fb != r_expected) begin
          w_err_nxt   = 1'b1;
          w_steps_nxt = 8'd0;
          w_state_nxt = ST_DONE;
        end else begin
          w_steps_nxt = w_steps_dec;
          w_state_nxt = (w_steps_dec != 8'd0) ? ST_CALC : ST_DONE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command payload registers carry no reset; they are only consulted after
  // an accept has reloaded them.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_steps <= 8'd0;
      r_j     <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_data     <= w_data_nxt;
      r_steps    <= w_steps_nxt;
      r_expected <= w_expected_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign j         = r_j;
  assign k         = r_k;
  assign err       = r_err;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq: a 4-bit JK flip-flop bank closes the loop on q_fb,
// a command-level model predicts every output cycle, plus literal spot checks.
module tb_jk_drive_seq;
  import jk_drive_pkg::*;

  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [7:0]   cmd_steps;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         busy;
  logic         done;
  logic         err;

  jk_drive_seq #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 Clock = ~Clock;

  // External JK bank; a stuck mask models a broken feedback line.
  logic [W-1:0] bank;
  logic [W-1:0] stuck_mask;
  logic [W-1:0] preset_val;
  logic         preset_en;
  always @(posedge Clock) begin
    if (preset_en) bank <= preset_val;
    else           bank <= (j & ~bank) | (~k & bank);
  end
  assign q_fb = bank & ~stuck_mask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge Clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         ready;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         err;
  } exp_t;

  function automatic exp_t mk(input logic b, input logic d, input logic r,
                              input logic [W-1:0] jj, input logic [W-1:0] kk, input logic e);
    exp_t x;
    x.busy = b; x.done = d; x.ready = r; x.j = jj; x.k = kk; x.err = e;
    return x;
  endfunction

  exp_t         exp_q[$];
  exp_t         e_cur;
  logic [W-1:0] m_bank;
  logic [W-1:0] m_mask;
  logic         m_err;
  logic         mon_en;
  logic         prev_drive;
  int           drive_cnt, done_cnt, done_cyc, acc_cyc;
  logic [W-1:0] last_j, last_k;
  logic [W-1:0] qhist[$];

  // Per-cycle compare; an empty expectation queue means the block must idle.
  always @(negedge Clock) begin
    if (mon_en) begin
      if (exp_q.size() > 0) e_cur = exp_q.pop_front();
      else                  e_cur = mk(1'b0, 1'b0, 1'b1, '0, '0, m_err);
      chk("busy",  busy,      e_cur.busy);
      chk("done",  done,      e_cur.done);
      chk("ready", cmd_ready, e_cur.ready);
      chk("j",     j,         e_cur.j);
      chk("k",     k,         e_cur.k);
      chk("err",   err,       e_cur.err);
      if (prev_drive) qhist.push_back(q_fb);
      if (j != '0 || k != '0) begin
        drive_cnt++;
        last_j = j;
        last_k = k;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_drive = (j != '0 || k != '0);
    end else begin
      prev_drive = 1'b0;
    end
  end

  task automatic preset(input logic [W-1:0] v, input logic [W-1:0] mask);
    @(posedge Clock); #1;
    preset_en  = 1'b1;
    preset_val = v;
    @(posedge Clock); #1;
    preset_en  = 1'b0;
    stuck_mask = mask;
    m_bank     = v;
    m_mask     = mask;
  endtask

  // Expands one command into its expected cycle-by-cycle outputs, then issues it.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [7:0] steps, input bit noise);
    int           n;
    logic [W-1:0] obs, t, jj, kk;
    logic         bad;
    @(posedge Clock); #1;
    drive_cnt = 0; done_cnt = 0; done_cyc = -1;
    qhist.delete();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0, m_err));
    n   = (op == OP_LOAD) ? 1 : int'(steps);
    bad = 1'b0;
    for (int s = 0; s < n && !bad; s++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0));
      obs = m_bank & ~m_mask;
      case (op)
        OP_LOAD:       t = data;
        OP_COUNT_UP:   t = obs + 4'd1;
        OP_COUNT_DOWN: t = obs - 4'd1;
        default:       t = ~obs;
      endcase
      jj = ~obs & t;
      kk = obs & ~t;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, jj, kk, 1'b0));
      m_bank = (jj & ~m_bank) | (~kk & m_bank);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0));
      if ((m_bank & ~m_mask) != t) bad = 1'b1;
    end
    if (n == 0) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, '0, bad));
    m_err = bad;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    @(posedge Clock); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    if (noise) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = ~data;
      cmd_steps = 8'd9;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      cmd_valid = 1'b0;
    end
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge Clock);
    if (exp_q.size() != 0) begin
      chk("cmd_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_steps = '0;
    stuck_mask = '0; preset_en = 1'b0; preset_val = '0;
    mon_en = 1'b0; m_err = 1'b0; m_bank = '0; m_mask = '0; prev_drive = 1'b0;
    drive_cnt = 0; done_cnt = 0; done_cyc = -1; acc_cyc = 0; last_j = '0; last_k = '0;

    repeat (3) @(posedge Clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_j", j, 4'h0);
    chk("rst_k", k, 4'h0);
    chk("rst_err", err, 1'b0);
    reset = 1'b1;
    @(posedge Clock); #1;
    chk("rst_ready_after_release", cmd_ready, 1'b1);
    mon_en = 1'b1;

    // LOAD 4'hA from 4'h3
    preset(4'h3, 4'h0);
    run_cmd(OP_LOAD, 4'hA, 8'd0, 1'b0);
    chk("load_j", last_j, 4'h8);
    chk("load_k", last_k, 4'h1);
    chk("load_q", bank, 4'hA);
    chk("load_drives", drive_cnt, 1);
    chk("load_done_edges_after_accept", done_cyc - acc_cyc, 3);
    chk("load_err", err, 1'b0);

    // COUNT_UP x3 from 4'hE, wrapping through zero, with ignored busy-time commands
    preset(4'hE, 4'h0);
    run_cmd(OP_COUNT_UP, 4'h0, 8'd3, 1'b1);
    chk("up_drives", drive_cnt, 3);
    chk("up_dones", done_cnt, 1);
    chk("up_hist_len", qhist.size(), 3);
    if (qhist.size() == 3) begin
      chk("up_q1", qhist[0], 4'hF);
      chk("up_q2", qhist[1], 4'h0);
      chk("up_q3", qhist[2], 4'h1);
    end
    chk("up_done_edges_after_accept", done_cyc - acc_cyc, 9);

    // COUNT_DOWN x1 from zero wraps to all-ones
    preset(4'h0, 4'h0);
    run_cmd(OP_COUNT_DOWN, 4'h0, 8'd1, 1'b0);
    chk("down_j", last_j, 4'hF);
    chk("down_k", last_k, 4'h0);
    chk("down_q", bank, 4'hF);

    // COMPLEMENT x2 from 4'h5
    preset(4'h5, 4'h0);
    run_cmd(OP_COMPLEMENT, 4'h0, 8'd2, 1'b0);
    chk("comp_hist_len", qhist.size(), 2);
    if (qhist.size() == 2) begin
      chk("comp_q1", qhist[0], 4'hA);
      chk("comp_q2", qhist[1], 4'h5);
    end

    // COMPLEMENT with zero steps: no drive, done one edge after the CALC edge
    run_cmd(OP_COMPLEMENT, 4'h0, 8'd0, 1'b0);
    chk("comp0_drives", drive_cnt, 0);
    chk("comp0_done_edges_after_accept", done_cyc - acc_cyc, 1);
    chk("comp0_q", bank, 4'h5);

    // Feedback bit0 stuck at zero
    preset(4'h0, 4'h1);
    run_cmd(OP_LOAD, 4'h1, 8'd0, 1'b0);
    chk("stuck_load_err", err, 1'b1);
    chk("stuck_load_dones", done_cnt, 1);
    preset(4'h0, 4'h1);
    run_cmd(OP_COUNT_UP, 4'h0, 8'd3, 1'b0);
    chk("stuck_up_drives", drive_cnt, 1);
    chk("stuck_up_err", err, 1'b1);
    preset(4'h2, 4'h0);
    run_cmd(OP_LOAD, 4'h7, 8'd0, 1'b0);
    chk("err_cleared", err, 1'b0);
    chk("clear_q", bank, 4'h7);

    // Reset during the first DRIVE cycle of COUNT_UP x5
    preset(4'h0, 4'h0);
    mon_en = 1'b0;
    @(posedge Clock); #1;
    cmd_valid = 1'b1; cmd_op = OP_COUNT_UP; cmd_data = '0; cmd_steps = 8'd5;
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
    chk("abort_busy_calc", busy, 1'b1);
    @(posedge Clock); #1;
    chk("abort_drive_j", j, 4'h1);
    reset = 1'b0;
    @(posedge Clock); #1;
    chk("abort_j", j, 4'h0);
    chk("abort_k", k, 4'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    reset = 1'b1;
    @(posedge Clock); #1;
    chk("abort_ready_after_release", cmd_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge Clock); #1;
      chk("abort_no_done", done, 1'b0);
    end
    m_bank = bank;
    m_err  = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;

    // Normal operation after the abort
    run_cmd(OP_LOAD, 4'h6, 8'd0, 1'b0);
    chk("post_j", last_j, 4'h6);
    chk("post_k", last_k, 4'h1);
    chk("post_q", bank, 4'h6);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
